// File: rtl/thanos_mine_dropper.sv
// Mine dropper: samples the carrier position on drop attempts, places grid-snapped
// mines into a slot pool and runs each slot through fuse and blast countdowns.
module thanos_mine_dropper #(
    parameter int NUM_MINES    = 4,
    parameter int DROP_PERIOD  = 60,
    parameter int FUSE_FRAMES  = 90,
    parameter int BLAST_FRAMES = 15,
    parameter int X_OFFSET     = 16,
    parameter int Y_OFFSET     = 64,
    parameter int GRID         = 32
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       startOfFrame,
    input  logic                       enable,
    input  logic signed [10:0]         carrierX,
    input  logic signed [10:0]         carrierY,
    input  logic                       defuseReq,
    input  logic [2:0]                 defuseIdx,
    output logic [NUM_MINES*11-1:0]    mineX,
    output logic [NUM_MINES*11-1:0]    mineY,
    output logic [NUM_MINES-1:0]       mineArmed,
    output logic [NUM_MINES-1:0]       mineBlast,
    output logic                       dropPulse,
    output logic                       blastPulse,
    output logic                       skipPulse
);

    localparam int CW = $clog2((FUSE_FRAMES > BLAST_FRAMES ? FUSE_FRAMES : BLAST_FRAMES) + 1);
    localparam int TW = $clog2(DROP_PERIOD) + 1;
    localparam logic [10:0] SNAP_MASK = ~11'(GRID - 1);

    typedef enum logic [1:0] {FREE, ARMED, BLAST} slot_state_t;

    slot_state_t       r_state [NUM_MINES];
    slot_state_t       w_state_nx [NUM_MINES];
    logic [CW-1:0]     r_cnt [NUM_MINES];
    logic [CW-1:0]     w_cnt_nx [NUM_MINES];
    logic [10:0]       r_x [NUM_MINES];
    logic [10:0]       r_y [NUM_MINES];
    logic [10:0]       w_x_nx [NUM_MINES];
    logic [10:0]       w_y_nx [NUM_MINES];
    logic [TW-1:0]     r_timer, w_timer_nx;
    logic              r_drop, r_blast, r_skip;
    logic              w_drop_nx, w_blast_nx, w_skip_nx;
    logic [11:0]       w_tx_raw, w_ty_raw;
    logic [10:0]       w_tgt_x, w_tgt_y;
    logic              w_attempt, w_have_free, w_dup;
    logic [3:0]        w_free_idx;

    // Negative targets clamp to 0 before snapping to the grid.
    always_comb begin
        w_tx_raw = {carrierX[10], carrierX} + 12'(X_OFFSET);
        w_ty_raw = {carrierY[10], carrierY} + 12'(Y_OFFSET);
        w_tgt_x  = w_tx_raw[11] ? '0 : (w_tx_raw[10:0] & SNAP_MASK);
        w_tgt_y  = w_ty_raw[11] ? '0 : (w_ty_raw[10:0] & SNAP_MASK);
    end

    always_comb begin
        w_have_free = 1'b0;
        w_free_idx  = '0;
        w_dup       = 1'b0;
        for (int unsigned i = 0; i < NUM_MINES; i++) begin
            if (!w_have_free && r_state[i] == FREE) begin
                w_have_free = 1'b1;
                w_free_idx  = 4'(i);
            end
            if (r_state[i] != FREE && r_x[i] == w_tgt_x && r_y[i] == w_tgt_y)
                w_dup = 1'b1;
        end
    end

    always_comb begin
        w_timer_nx = r_timer;
        w_attempt  = 1'b0;
        if (startOfFrame && enable) begin
            if (r_timer == TW'(DROP_PERIOD - 1)) begin
                w_attempt  = 1'b1;
                w_timer_nx = '0;
            end else begin
                w_timer_nx = r_timer + 1'b1;
            end
        end
    end

    always_comb begin
        w_drop_nx  = 1'b0;
        w_blast_nx = 1'b0;
        w_skip_nx  = 1'b0;
        for (int unsigned i = 0; i < NUM_MINES; i++) begin
            w_state_nx[i] = r_state[i];
            w_cnt_nx[i]   = r_cnt[i];
            w_x_nx[i]     = r_x[i];
            w_y_nx[i]     = r_y[i];
            if (startOfFrame) begin
                case (r_state[i])
                    ARMED: begin
                        if (r_cnt[i] <= CW'(1)) begin
                            w_state_nx[i] = BLAST;
                            w_cnt_nx[i]   = CW'(BLAST_FRAMES);
                        end else begin
                            w_cnt_nx[i] = r_cnt[i] - 1'b1;
                        end
                    end
                    BLAST: begin
                        if (r_cnt[i] <= CW'(1))
                            w_state_nx[i] = FREE;
                        else
                            w_cnt_nx[i] = r_cnt[i] - 1'b1;
                    end
                    default: ;
                endcase
            end
            // Defuse overrides a same-cycle fuse expiry, so no blast is reported.
            if (defuseReq && 32'(defuseIdx) == i && r_state[i] == ARMED)
                w_state_nx[i] = FREE;
            if (r_state[i] == ARMED && w_state_nx[i] == BLAST)
                w_blast_nx = 1'b1;
            if (w_attempt && w_have_free && !w_dup && 32'(w_free_idx) == i) begin
                w_state_nx[i] = ARMED;
                w_cnt_nx[i]   = CW'(FUSE_FRAMES);
                w_x_nx[i]     = w_tgt_x;
                w_y_nx[i]     = w_tgt_y;
            end
        end
        if (w_attempt) begin
            w_drop_nx = w_have_free && !w_dup;
            w_skip_nx = !(w_have_free && !w_dup);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int unsigned i = 0; i < NUM_MINES; i++) begin
                r_state[i] <= FREE;
                r_cnt[i]   <= '0;
                r_x[i]     <= '0;
                r_y[i]     <= '0;
            end
            r_timer <= '0;
            r_drop  <= 1'b0;
            r_blast <= 1'b0;
            r_skip  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_MINES; i++) begin
                r_state[i] <= w_state_nx[i];
                r_cnt[i]   <= w_cnt_nx[i];
                r_x[i]     <= w_x_nx[i];
                r_y[i]     <= w_y_nx[i];
            end
            r_timer <= w_timer_nx;
            r_drop  <= w_drop_nx;
            r_blast <= w_blast_nx;
            r_skip  <= w_skip_nx;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_MINES; i++) begin
            mineX[i*11 +: 11] = r_x[i];
            mineY[i*11 +: 11] = r_y[i];
            mineArmed[i]      = (r_state[i] == ARMED);
            mineBlast[i]      = (r_state[i] == BLAST);
        end
    end

    assign dropPulse  = r_drop;
    assign blastPulse = r_blast;
    assign skipPulse  = r_skip;

endmodule

// File: tb/tb_thanos_mine_dropper.sv
// Scoreboard bench for thanos_mine_dropper: a frame-age reference model queues the
// expected registered outputs per cycle; a monitor pops and compares after each edge.
module tb_thanos_mine_dropper;

    localparam int NM = 4;
    localparam int DP = 4;
    localparam int FF = 20;
    localparam int BF = 3;
    localparam int XO = 16;
    localparam int YO = 64;
    localparam int GR = 32;

    logic              clk = 1'b0;
    logic              resetN;
    logic              sof, en, defReq;
    logic [10:0]       cx, cy;
    logic [2:0]        defIdx;
    logic [NM*11-1:0]  mx, my;
    logic [NM-1:0]     marm, mbl;
    logic              dp, bp, sp;

    always #5 clk = ~clk;

    thanos_mine_dropper #(
        .NUM_MINES(NM), .DROP_PERIOD(DP), .FUSE_FRAMES(FF), .BLAST_FRAMES(BF),
        .X_OFFSET(XO), .Y_OFFSET(YO), .GRID(GR)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .enable(en),
        .carrierX(cx), .carrierY(cy), .defuseReq(defReq), .defuseIdx(defIdx),
        .mineX(mx), .mineY(my), .mineArmed(marm), .mineBlast(mbl),
        .dropPulse(dp), .blastPulse(bp), .skipPulse(sp)
    );

    typedef struct {
        logic             drop, blast, skip;
        logic [NM-1:0]    arm, bl;
        logic [NM*11-1:0] x, y;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   rnd_def = 1'b0;

    // Reference model: a mine's phase is derived from its age in frames.
    bit          m_used [NM];
    int          m_d [NM];
    logic [10:0] m_x [NM];
    logic [10:0] m_y [NM];
    int          fc, en_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int status(input int i, input int f);
        int age;
        if (!m_used[i]) return 0;
        age = f - m_d[i];
        if (age < FF) return 1;
        if (age < FF + BF) return 2;
        return 0;
    endfunction

    function automatic logic [10:0] snap(input int v);
        int t;
        t = (v < 0) ? 0 : v;
        t = (t / GR) * GR;
        return 11'(t);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NM; i++) begin
            m_used[i] = 1'b0; m_d[i] = 0; m_x[i] = '0; m_y[i] = '0;
        end
        fc = 0;
        en_cnt = 0;
    endtask

    task automatic model_step();
        exp_t          e;
        int            fn, slot;
        logic [NM-1:0] dmask;
        logic [10:0]   tx, ty;
        bit            attempt, dup;
        fn = fc + (sof ? 1 : 0);
        e.drop = 0; e.blast = 0; e.skip = 0;
        dmask = '0;
        for (int i = 0; i < NM; i++)
            if (defReq && int'(defIdx) == i && status(i, fc) == 1) dmask[i] = 1'b1;
        for (int i = 0; i < NM; i++)
            if (!dmask[i] && status(i, fc) == 1 && status(i, fn) == 2) e.blast = 1'b1;
        attempt = 1'b0;
        if (sof && en) begin
            en_cnt++;
            attempt = (en_cnt % DP) == 0;
        end
        slot = -1;
        dup = 1'b0;
        tx = snap(int'($signed(cx)) + XO);
        ty = snap(int'($signed(cy)) + YO);
        if (attempt) begin
            for (int i = NM - 1; i >= 0; i--) begin
                if (status(i, fc) == 0) slot = i;
                else if (m_x[i] == tx && m_y[i] == ty) dup = 1'b1;
            end
        end
        for (int i = 0; i < NM; i++)
            if (dmask[i]) m_used[i] = 1'b0;
        if (attempt) begin
            if (slot < 0 || dup) begin
                e.skip = 1'b1;
            end else begin
                e.drop = 1'b1;
                m_used[slot] = 1'b1; m_d[slot] = fn; m_x[slot] = tx; m_y[slot] = ty;
            end
        end
        fc = fn;
        for (int i = 0; i < NM; i++) begin
            e.arm[i] = (status(i, fc) == 1);
            e.bl[i]  = (status(i, fc) == 2);
            e.x[i*11 +: 11] = m_x[i];
            e.y[i*11 +: 11] = m_y[i];
        end
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("dropPulse", 64'(dp), 64'(e.drop));
            chk("blastPulse", 64'(bp), 64'(e.blast));
            chk("skipPulse", 64'(sp), 64'(e.skip));
            chk("mineArmed", 64'(marm), 64'(e.arm));
            chk("mineBlast", 64'(mbl), 64'(e.bl));
            chk("mineX", 64'(mx), 64'(e.x));
            chk("mineY", 64'(my), 64'(e.y));
        end
    end

    task automatic cyc(input bit s, input bit e, input logic [10:0] x, input logic [10:0] y,
                       input bit dr, input logic [2:0] di);
        @(negedge clk);
        sof = s; en = e; cx = x; cy = y; defReq = dr; defIdx = di;
        model_step();
    endtask

    // Idle gap cycles then one startOfFrame cycle; optionally defuse a slot on its expiry frame.
    task automatic frame(input int gap, input int x, input int y, input bit e, input bit def_exp);
        bit          dr;
        logic [2:0]  di;
        for (int g = 0; g < gap; g++) begin
            dr = rnd_def && ($urandom % 12 == 0);
            di = 3'($urandom % 8);
            cyc(0, e, 11'(x), 11'(y), dr, di);
        end
        dr = 1'b0;
        di = '0;
        if (def_exp) begin
            for (int i = NM - 1; i >= 0; i--)
                if (status(i, fc) == 1 && (fc + 1 - m_d[i]) == FF) begin
                    dr = 1'b1; di = 3'(i);
                end
        end
        cyc(1, e, 11'(x), 11'(y), dr, di);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_mineX"}, 64'(mx), 64'd0);
        chk({tag, "_mineY"}, 64'(my), 64'd0);
        chk({tag, "_armed"}, 64'(marm), 64'd0);
        chk({tag, "_blast"}, 64'(mbl), 64'd0);
        chk({tag, "_drop"}, 64'(dp), 64'd0);
        chk({tag, "_blastP"}, 64'(bp), 64'd0);
        chk({tag, "_skip"}, 64'(sp), 64'd0);
    endtask

    initial begin
        resetN = 1'b0; sof = 0; en = 0; cx = '0; cy = '0; defReq = 0; defIdx = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check_reset_state("reset");
        @(negedge clk);
        resetN = 1'b1;

        // Carrier (256,256): drop on the fourth frame.
        for (int f = 0; f < 4; f++) frame(2, 256, 256, 1, 0);
        settle();
        chk("first_drop_x", 64'(mx[10:0]), 64'd256);
        chk("first_drop_y", 64'(my[10:0]), 64'd320);
        chk("first_drop_armed", 64'(marm), 64'b0001);

        // Negative X clamps to 0.
        for (int f = 0; f < 4; f++) frame(1, -30, 10, 1, 0);
        settle();
        chk("clamp_x", 64'(mx[21:11]), 64'd0);
        chk("clamp_y", 64'(my[21:11]), 64'd64);

        for (int f = 0; f < 4; f++) frame(1, 64, 0, 1, 0);
        for (int f = 0; f < 4; f++) frame(1, 128, 0, 1, 0);
        for (int f = 0; f < 4; f++) frame(1, 192, 0, 1, 0);
        settle();
        chk("pool_full_skip", 64'(sp), 64'd1);
        chk("pool_full_armed", 64'(marm), 64'b1111);

        // Asynchronous reset mid-operation.
        @(posedge clk);
        #3 resetN = 1'b0;
        #1 check_reset_state("midreset");
        model_reset();
        sof = 0; defReq = 0;
        @(negedge clk);
        resetN = 1'b1;

        // Unchanged carrier gives a refused second drop.
        for (int f = 0; f < 8; f++) frame(1, 500, 300, 1, 0);
        settle();
        chk("dup_skip", 64'(sp), 64'd1);
        chk("dup_armed", 64'(marm), 64'b0001);

        // Defuse slot 0 on its expiry frame, then defuse free / out-of-range slots.
        for (int f = 0; f < 15; f++) frame(1, 500, 300, 0, 0);
        frame(1, 500, 300, 0, 1);
        settle();
        chk("defuse_expiry_armed", 64'(marm), 64'd0);
        chk("defuse_expiry_blast", 64'(mbl), 64'd0);
        chk("defuse_expiry_pulse", 64'(bp), 64'd0);
        cyc(0, 0, 11'd500, 11'd300, 1, 3'd0);
        cyc(0, 0, 11'd500, 11'd300, 1, 3'd6);

        // Randomised operation.
        rnd_def = 1'b1;
        for (int f = 0; f < 300; f++) begin
            int x, y;
            x = 32 * $urandom_range(0, 5) - 40;
            y = 32 * $urandom_range(0, 2) - 70;
            frame($urandom_range(0, 3), x, y, ($urandom % 10) != 0, ($urandom % 3) == 0);
        end
        settle();
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
